// File: rtl/fp_exp_seq.sv
// Sequential floating-point exponent datapath: alignment (ADD), MUL/DIV bias
// adjustment and NORM, with overflow/underflow flags and a global stall.
module fp_exp_seq #(
    parameter int EW = 11,
    parameter int NW = 8,
    parameter int SW = 6,
    localparam int IW = EW + 5
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          fpuhold,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic          prec,
    input  logic [EW-1:0] aexpin,
    input  logic [EW-1:0] bexpin,
    input  logic [SW-1:0] lzc,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] rexp,
    output logic [SW-1:0] sa,
    output logic          a_ge_b,
    output logic          ovf,
    output logic          unf,
    output logic          azero,
    output logic          bzero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ADJ  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0]    OP_ADD  = 2'd0;
    localparam logic [1:0]    OP_MUL  = 2'd1;
    localparam logic [1:0]    OP_DIV  = 2'd2;
    localparam logic [1:0]    OP_NORM = 2'd3;

    localparam logic [EW-1:0] NW_MASK = {{(EW-NW){1'b0}}, {NW{1'b1}}};
    localparam logic [IW-1:0] BIAS_W  = {{(IW-EW+1){1'b0}}, {(EW-1){1'b1}}};
    localparam logic [IW-1:0] BIAS_N  = {{(IW-NW+1){1'b0}}, {(NW-1){1'b1}}};
    localparam logic [IW-1:0] MAX_W   = {{(IW-EW){1'b0}}, {EW{1'b1}}};
    localparam logic [IW-1:0] MAX_N   = {{(IW-NW){1'b0}}, {NW{1'b1}}};
    localparam logic [SW-1:0] SA_MAX  = {SW{1'b1}};

    state_t        state_q, state_d;
    logic [IW-1:0] a_q, a_d, b_q, b_d, t_q, t_d, rexp_q, rexp_d;
    logic [1:0]    op_q, op_d;
    logic          prec_q, prec_d;
    logic [SW-1:0] lzc_q, lzc_d, sa_q, sa_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          age_q, age_d, ovf_q, ovf_d, unf_q, unf_d;
    logic          azero_q, azero_d, bzero_q, bzero_d;

    logic [EW-1:0] a_in_s, b_in_s;
    logic [IW-1:0] bias_s, lim_s, t_abs_s, lzc_ext_s;
    logic          t_neg_s;

    assign busy   = busy_q;
    assign done   = done_q;
    assign rexp   = rexp_q;
    assign sa     = sa_q;
    assign a_ge_b = age_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign azero  = azero_q;
    assign bzero  = bzero_q;

    // Operand masking and precision-dependent constants feeding the datapath.
    always_comb begin
        a_in_s    = prec ? aexpin : (aexpin & NW_MASK);
        b_in_s    = prec ? bexpin : (bexpin & NW_MASK);
        bias_s    = prec_q ? BIAS_W : BIAS_N;
        lim_s     = prec_q ? MAX_W : MAX_N;
        t_neg_s   = t_q[IW-1];
        t_abs_s   = t_neg_s ? ({IW{1'b0}} - t_q) : t_q;
        lzc_ext_s = {{(IW-SW){1'b0}}, lzc_q};
    end

    // Next-state and next-output logic; a stall simply keeps every flop.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        t_d     = t_q;
        op_d    = op_q;
        prec_d  = prec_q;
        lzc_d   = lzc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        rexp_d  = rexp_q;
        sa_d    = sa_q;
        age_d   = age_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        azero_d = azero_q;
        bzero_d = bzero_q;
        if (!fpuhold) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CALC;
                        a_d     = {5'd0, a_in_s};
                        b_d     = {5'd0, b_in_s};
                        op_d    = op;
                        prec_d  = prec;
                        lzc_d   = lzc;
                        azero_d = (a_in_s == {EW{1'b0}});
                        bzero_d = (b_in_s == {EW{1'b0}});
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    case (op_q)
                        OP_ADD:  t_d = a_q - b_q;
                        OP_MUL:  t_d = a_q + b_q - bias_s;
                        OP_DIV:  t_d = a_q - b_q + bias_s;
                        OP_NORM: t_d = a_q - lzc_ext_s;
                        default: t_d = {IW{1'b0}};
                    endcase
                    state_d = S_ADJ;
                end
                S_ADJ: begin
                    if (op_q == OP_ADD) begin
                        rexp_d = t_neg_s ? b_q : a_q;
                        age_d  = ~t_neg_s;
                        sa_d   = (t_abs_s > {{(IW-SW){1'b0}}, SA_MAX}) ? SA_MAX : t_abs_s[SW-1:0];
                        ovf_d  = 1'b0;
                        unf_d  = 1'b0;
                    end else begin
                        rexp_d = t_q;
                        age_d  = 1'b0;
                        sa_d   = {SW{1'b0}};
                        // lim_s is positive, so ovf and unf are mutually exclusive
                        ovf_d  = ($signed(t_q) >= $signed(lim_s));
                        unf_d  = t_neg_s || (t_q == {IW{1'b0}});
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, operand latches and registered outputs.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= S_IDLE;
            a_q     <= {IW{1'b0}};
            b_q     <= {IW{1'b0}};
            t_q     <= {IW{1'b0}};
            op_q    <= 2'd0;
            prec_q  <= 1'b0;
            lzc_q   <= {SW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rexp_q  <= {IW{1'b0}};
            sa_q    <= {SW{1'b0}};
            age_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            azero_q <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            t_q     <= t_d;
            op_q    <= op_d;
            prec_q  <= prec_d;
            lzc_q   <= lzc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rexp_q  <= rexp_d;
            sa_q    <= sa_d;
            age_q   <= age_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            azero_q <= azero_d;
            bzero_q <= bzero_d;
        end
    end

endmodule

// File: tb/tb_fp_exp_seq.sv
// Self-checking bench for fp_exp_seq: directed cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_fp_exp_seq;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        fpuhold = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic        prec = 1'b0;
    logic [10:0] aexpin = 11'd0;
    logic [10:0] bexpin = 11'd0;
    logic [5:0]  lzc = 6'd0;
    logic        busy, done, a_ge_b, ovf, unf, azero, bzero;
    logic [15:0] rexp;
    logic [5:0]  sa;

    int n_checks = 0;
    int n_pass   = 0;

    fp_exp_seq dut (
        .clk(clk), .reset_l(reset_l), .fpuhold(fpuhold), .start(start),
        .op(op), .prec(prec), .aexpin(aexpin), .bexpin(bexpin), .lzc(lzc),
        .busy(busy), .done(done), .rexp(rexp), .sa(sa), .a_ge_b(a_ge_b),
        .ovf(ovf), .unf(unf), .azero(azero), .bzero(bzero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {busy, done, rexp, sa, a_ge_b, ovf, unf, azero, bzero}, 32'd0);
    endtask

    // Reference: plain integer arithmetic straight from the exponent rules.
    task automatic model(input int o, input int p, input int a, input int b, input int l,
                         output int e_rexp, output int e_sa, output int e_age,
                         output int e_ovf, output int e_unf, output int e_az, output int e_bz);
        int am, bm, bias, lim, t, mag;
        am   = p ? a : (a % 256);
        bm   = p ? b : (b % 256);
        bias = p ? 1023 : 127;
        lim  = p ? 2047 : 255;
        e_az = (am == 0);
        e_bz = (bm == 0);
        e_sa = 0; e_age = 0; e_ovf = 0; e_unf = 0;
        if (o == 0) begin
            mag    = (am >= bm) ? am - bm : bm - am;
            e_rexp = (am >= bm) ? am : bm;
            e_age  = (am >= bm);
            e_sa   = (mag > 63) ? 63 : mag;
        end else begin
            if (o == 1)      t = am + bm - bias;
            else if (o == 2) t = am - bm + bias;
            else             t = am - l;
            e_rexp = t & 32'hFFFF;
            e_ovf  = (t >= lim);
            e_unf  = (t <= 0);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic p, input logic [10:0] a,
                          input logic [10:0] b, input logic [5:0] l,
                          input int hold_adj, input int hold_done, input bit spam);
        int e_rexp, e_sa, e_age, e_ovf, e_unf, e_az, e_bz, lat;
        model(int'(o), int'(p), int'(a), int'(b), int'(l),
              e_rexp, e_sa, e_age, e_ovf, e_unf, e_az, e_bz);
        @(posedge clk); #1;
        start = 1'b1; op = o; prec = p; aexpin = a; bexpin = b; lzc = l;
        @(posedge clk); #1;
        lat = 1;
        if (spam) begin
            op = ~o; aexpin = ~a; bexpin = ~b; lzc = ~l;
        end else begin
            start = 1'b0;
        end
        check("busy_calc", {31'd0, busy}, 32'd1);
        if (hold_adj > 0) begin
            @(posedge clk); #1;
            lat++;
            fpuhold = 1'b1;
            repeat (hold_adj) begin
                @(posedge clk); #1;
                lat++;
                check("done_in_hold", {31'd0, done}, 32'd0);
            end
            fpuhold = 1'b0;
        end
        while (!done && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("latency", lat, 3 + hold_adj);
        check("rexp", {16'd0, rexp}, e_rexp);
        check("sa", {26'd0, sa}, e_sa);
        check("flags", {27'd0, a_ge_b, ovf, unf, azero, bzero},
              {27'd0, e_age[0], e_ovf[0], e_unf[0], e_az[0], e_bz[0]});
        if (hold_done > 0) begin
            fpuhold = 1'b1;
            repeat (hold_done) begin
                @(posedge clk); #1;
                check("done_stalled", {31'd0, done}, 32'd1);
            end
            fpuhold = 1'b0;
        end
        @(posedge clk); #1;
        check("idle_after", {30'd0, busy, done}, 32'd0);
        check("rexp_hold", {16'd0, rexp}, e_rexp);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        #20;
        reset_l = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        run_op(2'd0, 1'b1, 11'h400, 11'h3FD, 6'd0, 0, 0, 1'b0);
        run_op(2'd0, 1'b1, 11'h001, 11'h7FE, 6'd0, 0, 0, 1'b0);
        run_op(2'd1, 1'b1, 11'h3FF, 11'h3FF, 6'd0, 0, 0, 1'b0);
        run_op(2'd1, 1'b1, 11'h7FE, 11'h7FE, 6'd0, 0, 0, 1'b0);
        run_op(2'd2, 1'b0, 11'h001, 11'h0FE, 6'd0, 0, 0, 1'b0);
        run_op(2'd2, 1'b0, 11'h701, 11'h0FE, 6'd0, 0, 0, 1'b0);
        run_op(2'd3, 1'b1, 11'h005, 11'h000, 6'd5, 2, 0, 1'b0);
        run_op(2'd1, 1'b0, 11'h0F0, 11'h0A0, 6'd0, 0, 3, 1'b1);
        run_op(2'd0, 1'b0, 11'h000, 11'h000, 6'd0, 0, 0, 1'b0);

        // Reset asserted while in CALC, also with the stall active.
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; prec = 1'b1; aexpin = 11'h7FE; bexpin = 11'h7FE;
        @(posedge clk); #1;
        start = 1'b0;
        fpuhold = 1'b1;
        reset_l = 1'b0;
        #2;
        check_all_zero("mid_reset");
        reset_l = 1'b1;
        fpuhold = 1'b0;
        begin
            int seen_done;
            seen_done = 0;
            repeat (5) begin
                @(posedge clk); #1;
                if (done) seen_done = 1;
            end
            check("no_done_after_abort", seen_done, 0);
        end
        check_all_zero("after_abort");
        run_op(2'd0, 1'b1, 11'h400, 11'h3FD, 6'd0, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [10:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
            run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rb,
                   6'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_exp_seq.md
FP_EXP_SEQ -- requirements
Module: fp_exp_seq

Interface
REQ-001 Parameter EW, default 11, wide (double) exponent field width.
REQ-002 Parameter NW, default 8, narrow (single) exponent field width; NW < EW.
REQ-003 Parameter SW, default 6, shift-amount and leading-zero-count width.
REQ-004 Derived IW = EW+5: internal two's-complement width (16 at defaults).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_l  input  1  asynchronous, active-low reset.
REQ-007 fpuhold  input  1  global stall; 1 freezes all state.
REQ-008 start  input  1  operation request, sampled in IDLE only.
REQ-009 op  input  2  00 ADD-align, 01 MUL, 10 DIV, 11 NORM.
REQ-010 prec  input  1  1 = wide format (EW, bias 2^(EW-1)-1); 0 = narrow (NW, bias 2^(NW-1)-1).
REQ-011 aexpin, bexpin  input  EW  biased exponents; narrow values right-aligned, upper bits ignored.
REQ-012 lzc  input  SW  leading-zero count for NORM.
REQ-013 busy  output  1  high in CALC, ADJ, DONE.
REQ-014 done  output  1  result-valid strobe.
REQ-015 rexp  output  IW  result exponent, two's complement, unclamped.
REQ-016 sa  output  SW  alignment shift amount (ADD only, else 0).
REQ-017 a_ge_b  output  1  a >= b (ADD only, else 0).
REQ-018 ovf, unf  output  1  exponent overflow / underflow.
REQ-019 azero, bzero  output  1  latched operand exponent equals zero.

Function
REQ-020 FSM states IDLE, CALC, ADJ, DONE; transitions IDLE->CALC on start & ~fpuhold, CALC->ADJ, ADJ->DONE, DONE->IDLE, each only when fpuhold=0.
REQ-021 On acceptance, a, b, op, prec, lzc SHALL be latched, zero-extended to IW, narrow inputs masked to NW bits when prec=0.
REQ-022 start outside IDLE SHALL be ignored; no queuing.
REQ-023 CALC computes t: ADD t=a-b; MUL t=a+b-bias; DIV t=a-b+bias; NORM t=a-lzc; all IW-bit modular arithmetic.
REQ-024 ADD in ADJ: rexp=max(a,b), a_ge_b=~t[IW-1], sa=min(|t|, 2^SW-1), ovf=unf=0.
REQ-025 MUL/DIV/NORM in ADJ: rexp=t, ovf = signed t >= all-ones of selected width (2^EW-1 or 2^NW-1), unf = signed t <= 0, sa=0, a_ge_b=0.
REQ-026 Result outputs SHALL register at ADJ->DONE and hold until the next accepted start.
REQ-027 done SHALL be high exactly while in DONE; unstalled latency start-sample edge to done = 3 cycles.
REQ-028 fpuhold=1 SHALL freeze state, latches and outputs; done held in DONE stays high for the stall duration.
REQ-029 azero/bzero SHALL update at acceptance from the latched masked operands.
REQ-030 ovf and unf SHALL never both be 1.

Reset
REQ-031 reset_l=0 SHALL force IDLE and all outputs to 0 asynchronously, regardless of fpuhold.
REQ-032 Reset mid-operation SHALL abort it with no done pulse; first start after release behaves normally.

Verification
REQ-033 ADD prec=1 a=0x400 b=0x3FD -> rexp=0x0400, sa=3, a_ge_b=1, done exactly 3 cycles after start.
REQ-034 ADD prec=1 a=0x001 b=0x7FE -> rexp=0x07FE, sa=63 (saturated), a_ge_b=0.
REQ-035 MUL prec=1 a=b=0x3FF -> rexp=0x03FF, ovf=unf=0; a=b=0x7FE -> rexp=0x0BFD, ovf=1.
REQ-036 DIV prec=0 a=0x001 b=0x0FE -> rexp=0xFF82 (-126), unf=1; aexpin=0x701 same result (upper bits masked).
REQ-037 NORM prec=1 a=0x005 lzc=5 -> rexp=0, unf=1, azero=0; fpuhold high 2 cycles during ADJ -> done at start+5.
REQ-038 reset_l pulsed low in CALC -> no done, all outputs 0; start issued during busy ignored.
